// File: rtl/uart_wb_bridge_if.sv
// Wishbone bus bundle between the UART bridge (master) and the attached slave.
interface uart_wb_bridge_if;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [3:0]  wb_sel_o;
   logic        wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_sel_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/uart_wb_bridge.sv
// UART-to-Wishbone command bridge: 'w' + addr + data writes, 'r' + addr reads,
// replies '.' for write, 4 data bytes for read, '!' on ack watchdog expiry.
module uart_wb_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_avail,
   output logic       rx_ack,
   output logic [7:0] tx_data,
   output logic       tx_wr,
   input  logic       tx_busy,
   uart_wb_bridge_if.master bus
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WB, TX, TX_WAIT} state_t;

   localparam logic [15:0] TMO = TIMEOUT[15:0];

   state_t      state, state_next;
   logic [1:0]  cnt;
   logic [1:0]  tx_left;
   logic [15:0] wdog;
   logic [31:0] resp;
   logic [31:0] adr, dat;
   logic        is_write;
   logic        tx_hold;
   logic        cyc, stb, we;
   logic        take, fire, wb_done, wb_tmo;

   assign bus.wb_adr_o = adr;
   assign bus.wb_dat_o = dat;
   assign bus.wb_we_o  = we;
   assign bus.wb_stb_o = stb;
   assign bus.wb_cyc_o = cyc;
   assign bus.wb_sel_o = 4'hF;

   // State register; reset abandons any partial command immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode plus the one-cycle strobes that drive the datapath
   always_comb begin
      state_next = state;
      take       = 1'b0;
      fire       = 1'b0;
      wb_done    = 1'b0;
      wb_tmo     = 1'b0;
      case (state)
         IDLE: begin
            if (rx_avail && !rx_ack) begin
               take = 1'b1;
               if (rx_data == 8'h77 || rx_data == 8'h72) state_next = ADDR;
            end
         end
         ADDR: begin
            if (rx_avail && !rx_ack) begin
               take = 1'b1;
               if (cnt == 2'd3) state_next = is_write ? DATA : WB;
            end
         end
         DATA: begin
            if (rx_avail && !rx_ack) begin
               take = 1'b1;
               if (cnt == 2'd3) state_next = WB;
            end
         end
         WB: begin
            if (bus.wb_ack_i) begin
               wb_done    = 1'b1;
               state_next = TX;
            end else if (wdog == TMO) begin
               wb_tmo     = 1'b1;
               state_next = TX;
            end
         end
         TX: begin
            if (!tx_busy) begin
               fire       = 1'b1;
               state_next = TX_WAIT;
            end
         end
         TX_WAIT: begin
            if (!tx_hold && !tx_busy) state_next = (tx_left == 2'd0) ? IDLE : TX;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: byte capture, Wishbone cycle control, watchdog and reply shifting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt      <= 2'd0;
         tx_left  <= 2'd0;
         wdog     <= 16'd0;
         resp     <= 32'd0;
         adr      <= 32'd0;
         dat      <= 32'd0;
         is_write <= 1'b0;
         tx_hold  <= 1'b0;
         cyc      <= 1'b0;
         stb      <= 1'b0;
         we       <= 1'b0;
         rx_ack   <= 1'b0;
         tx_wr    <= 1'b0;
         tx_data  <= 8'd0;
      end else begin
         rx_ack <= take;
         tx_wr  <= fire;

         if (state == IDLE) begin
            cnt <= 2'd0;
            if (take) is_write <= (rx_data == 8'h77);
         end

         if (take && state == ADDR) begin
            adr <= {adr[23:0], rx_data};
            cnt <= cnt + 2'd1;
         end

         if (take && state == DATA) begin
            dat <= {dat[23:0], rx_data};
            cnt <= cnt + 2'd1;
         end

         if (state != WB && state_next == WB) begin
            cyc  <= 1'b1;
            stb  <= 1'b1;
            we   <= is_write;
            wdog <= 16'd0;
         end

         if (state == WB) begin
            if (wb_done || wb_tmo) begin
               cyc <= 1'b0;
               stb <= 1'b0;
               we  <= 1'b0;
            end else begin
               wdog <= wdog + 16'd1;
            end
            if (wb_done && is_write) begin
               resp    <= {8'h2E, 24'd0};
               tx_left <= 2'd0;
            end else if (wb_done) begin
               resp    <= bus.wb_dat_i;
               tx_left <= 2'd3;
            end else if (wb_tmo) begin
               resp    <= {8'h21, 24'd0};
               tx_left <= 2'd0;
            end
         end

         if (fire) begin
            tx_data <= resp[31:24];
            resp    <= {resp[23:0], 8'd0};
            tx_hold <= 1'b1;
         end

         if (state == TX_WAIT) begin
            if (tx_hold) tx_hold <= 1'b0;
            else if (!tx_busy && tx_left != 2'd0) tx_left <= tx_left - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: UART byte source, Wishbone slave model, TX sink.
module tb_uart_wb_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_avail = 1'b0;
   logic        rx_ack;
   logic [7:0]  tx_data;
   logic        tx_wr;
   logic        tx_busy;
   logic        force_busy = 1'b0;
   logic        auto_busy = 1'b0;
   int          auto_cnt = 0;

   int checks = 0;
   int failures = 0;

   int          cyc_num = 0;
   logic        ack_q = 1'b0;
   logic        ack_en = 1'b1;
   int          ack_delay = 3;
   int          wait_cnt = 0;
   logic [31:0] rdata = 32'd0;
   int          txn_count = 0;
   logic [31:0] log_adr, log_dat;
   logic        log_we;
   logic [3:0]  log_sel;
   int          ack_cycle = 0;
   int          cyc_hi = 0;

   logic [7:0]  txq[$];
   int          tx_first_cycle = -1;
   int          tx_viol = 0;
   int          rx_viol = 0;
   logic        prev_wr = 1'b0;
   logic        prev_rx_ack = 1'b0;

   uart_wb_bridge_if bus();

   uart_wb_bridge #(.TIMEOUT(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_avail (rx_avail),
      .rx_ack   (rx_ack),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .tx_busy  (tx_busy),
      .bus      (bus)
   );

   assign bus.wb_dat_i = rdata;
   assign bus.wb_ack_i = ack_q;
   assign tx_busy = force_busy || (auto_cnt != 0);

   always #5 clk = ~clk;

   always @(posedge clk) cyc_num++;

   // Wishbone slave: acks after ack_delay waiting cycles and logs the transfer
   always @(negedge clk) begin
      if (bus.wb_cyc_o) cyc_hi++;
      if (bus.wb_cyc_o && bus.wb_stb_o && ack_en && !ack_q) begin
         if (wait_cnt == ack_delay) begin
            ack_q = 1'b1;
            txn_count++;
            log_adr = bus.wb_adr_o;
            log_dat = bus.wb_dat_o;
            log_we = bus.wb_we_o;
            log_sel = bus.wb_sel_o;
            ack_cycle = cyc_num + 1;
         end else begin
            wait_cnt++;
         end
      end else begin
         ack_q = 1'b0;
         if (!bus.wb_cyc_o) wait_cnt = 0;
      end
   end

   // TX sink: collects bytes, flags writes while busy or back-to-back pulses
   always @(negedge clk) begin
      if (tx_wr) begin
         txq.push_back(tx_data);
         if (tx_first_cycle < 0) tx_first_cycle = cyc_num;
         if (tx_busy || prev_wr) tx_viol++;
         if (auto_busy) auto_cnt = 3;
      end else if (auto_cnt > 0) begin
         auto_cnt--;
      end
      prev_wr = tx_wr;
      if (rx_ack && prev_rx_ack) rx_viol++;
      prev_rx_ack = rx_ack;
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      rx_data = b;
      rx_avail = 1'b1;
      n = 0;
      while (!rx_ack && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rx_ack !== 1'b1) begin
         failures++;
         $display("FAIL rx_ack_wait byte=%02h got=%0b want=1", b, rx_ack);
      end
      rx_avail = 1'b0;
   endtask

   task automatic send_write(input logic [31:0] a, input logic [31:0] d);
      send_byte(8'h77);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
   endtask

   task automatic send_read(input logic [31:0] a);
      send_byte(8'h72);
      for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
   endtask

   task automatic wait_tx(input int n);
      int k;
      k = 0;
      while (txq.size() < n && k < 3000) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (txq.size() < n) begin
         failures++;
         $display("FAIL tx_wait got=%0d bytes want=%0d", txq.size(), n);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic clear_logs();
      txq.delete();
      tx_first_cycle = -1;
      txn_count = 0;
      cyc_hi = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 9;
      if (rx_ack !== 1'b0) begin failures++; $display("FAIL rst_rx_ack got=%0b want=0", rx_ack); end
      if (tx_wr !== 1'b0) begin failures++; $display("FAIL rst_tx_wr got=%0b want=0", tx_wr); end
      if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%02h want=00", tx_data); end
      if (bus.wb_cyc_o !== 1'b0) begin failures++; $display("FAIL rst_cyc got=%0b want=0", bus.wb_cyc_o); end
      if (bus.wb_stb_o !== 1'b0) begin failures++; $display("FAIL rst_stb got=%0b want=0", bus.wb_stb_o); end
      if (bus.wb_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b want=0", bus.wb_we_o); end
      if (bus.wb_adr_o !== 32'h0) begin failures++; $display("FAIL rst_adr got=%08h want=0", bus.wb_adr_o); end
      if (bus.wb_dat_o !== 32'h0) begin failures++; $display("FAIL rst_dat got=%08h want=0", bus.wb_dat_o); end
      if (bus.wb_sel_o !== 4'hF) begin failures++; $display("FAIL rst_sel got=%h want=F", bus.wb_sel_o); end
      reset = 1'b1;
   endtask

   task automatic test_write();
      clear_logs();
      ack_en = 1'b1;
      ack_delay = 3;
      send_write(32'h0000_1000, 32'hDEAD_BEEF);
      wait_tx(1);
      checks += 7;
      if (txn_count !== 1) begin failures++; $display("FAIL wr_txn_count got=%0d want=1", txn_count); end
      if (log_adr !== 32'h0000_1000) begin failures++; $display("FAIL wr_adr got=%08h want=00001000", log_adr); end
      if (log_dat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_dat got=%08h want=DEADBEEF", log_dat); end
      if (log_we !== 1'b1 || log_sel !== 4'hF) begin failures++; $display("FAIL wr_we_sel got=%0b/%h want=1/F", log_we, log_sel); end
      if (txq.size() !== 1 || txq[0] !== 8'h2E) begin failures++; $display("FAIL wr_reply got=%0d bytes first=%02h want=1 byte 2E", txq.size(), txq[0]); end
      if (tx_first_cycle - ack_cycle > 2 || tx_first_cycle < ack_cycle) begin failures++; $display("FAIL wr_latency got=%0d want<=2", tx_first_cycle - ack_cycle); end
      if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin failures++; $display("FAIL wr_cyc_idle got=%0b%0b want=00", bus.wb_cyc_o, bus.wb_stb_o); end
   endtask

   task automatic test_read();
      logic [7:0] exp [4];
      clear_logs();
      rdata = 32'h1234_5678;
      exp = '{8'h12, 8'h34, 8'h56, 8'h78};
      send_read(32'h0000_1000);
      wait_tx(4);
      checks += 3;
      if (txn_count !== 1 || log_we !== 1'b0) begin failures++; $display("FAIL rd_txn got=%0d we=%0b want=1 we=0", txn_count, log_we); end
      if (log_adr !== 32'h0000_1000) begin failures++; $display("FAIL rd_adr got=%08h want=00001000", log_adr); end
      if (txq.size() !== 4) begin failures++; $display("FAIL rd_count got=%0d want=4", txq.size()); end
      for (int i = 0; i < 4 && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp[i]) begin failures++; $display("FAIL rd_byte%0d got=%02h want=%02h", i, txq[i], exp[i]); end
      end
   endtask

   task automatic test_timeout();
      clear_logs();
      ack_en = 1'b0;
      send_read(32'h0000_2000);
      wait_tx(1);
      checks += 3;
      if (cyc_hi < 16 || cyc_hi > 17) begin failures++; $display("FAIL tmo_cyc_len got=%0d want=16..17", cyc_hi); end
      if (txq.size() !== 1 || txq[0] !== 8'h21) begin failures++; $display("FAIL tmo_reply got=%0d bytes first=%02h want=1 byte 21", txq.size(), txq[0]); end
      if (bus.wb_cyc_o !== 1'b0) begin failures++; $display("FAIL tmo_cyc_drop got=%0b want=0", bus.wb_cyc_o); end
      clear_logs();
      ack_en = 1'b1;
      ack_delay = 1;
      send_write(32'h0000_2004, 32'h0102_0304);
      wait_tx(1);
      checks += 2;
      if (txn_count !== 1 || log_adr !== 32'h0000_2004 || log_dat !== 32'h0102_0304) begin failures++; $display("FAIL tmo_next_wr got=%0d %08h %08h want=1 00002004 01020304", txn_count, log_adr, log_dat); end
      if (txq.size() !== 1 || txq[0] !== 8'h2E) begin failures++; $display("FAIL tmo_next_reply got=%0d bytes first=%02h want=1 byte 2E", txq.size(), txq[0]); end
   endtask

   task automatic test_discard();
      clear_logs();
      rdata = 32'hCAFE_F00D;
      send_byte(8'h55);
      repeat (20) @(negedge clk);
      checks++;
      if (txq.size() !== 0) begin failures++; $display("FAIL junk_reply got=%0d bytes want=0", txq.size()); end
      send_read(32'h0000_0040);
      wait_tx(4);
      checks += 2;
      if (txn_count !== 1 || log_adr !== 32'h0000_0040 || log_we !== 1'b0) begin failures++; $display("FAIL junk_rd got=%0d %08h we=%0b want=1 00000040 we=0", txn_count, log_adr, log_we); end
      if (txq.size() !== 4 || txq[0] !== 8'hCA || txq[1] !== 8'hFE || txq[2] !== 8'hF0 || txq[3] !== 8'h0D) begin failures++; $display("FAIL junk_rd_reply got=%0d bytes want=CA FE F0 0D", txq.size()); end
   endtask

   task automatic test_reset_mid_wb();
      int k;
      clear_logs();
      ack_en = 1'b0;
      send_write(32'h0000_0300, 32'h1122_3344);
      k = 0;
      while (!bus.wb_cyc_o && k < 50) begin @(negedge clk); k++; end
      checks++;
      if (bus.wb_cyc_o !== 1'b1) begin failures++; $display("FAIL mid_cyc_start got=%0b want=1", bus.wb_cyc_o); end
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checks++;
      if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin failures++; $display("FAIL mid_async_drop got=%0b%0b want=00", bus.wb_cyc_o, bus.wb_stb_o); end
      @(negedge clk);
      reset = 1'b1;
      clear_logs();
      ack_en = 1'b1;
      ack_delay = 2;
      send_write(32'h0000_0304, 32'h5566_7788);
      wait_tx(1);
      checks += 2;
      if (txn_count !== 1 || log_adr !== 32'h0000_0304 || log_dat !== 32'h5566_7788) begin failures++; $display("FAIL mid_fresh_wr got=%0d %08h %08h want=1 00000304 55667788", txn_count, log_adr, log_dat); end
      if (txq.size() !== 1 || txq[0] !== 8'h2E) begin failures++; $display("FAIL mid_fresh_reply got=%0d bytes first=%02h want=1 byte 2E", txq.size(), txq[0]); end
   endtask

   task automatic test_back_to_back_busy();
      logic [7:0] exp [4];
      clear_logs();
      rdata = 32'hA1B2_C3D4;
      exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      @(posedge clk);
      #2 force_busy = 1'b1;
      send_read(32'h0000_0500);
      repeat (1000) @(posedge clk);
      checks++;
      if (txq.size() !== 0) begin failures++; $display("FAIL busy_hold got=%0d bytes want=0", txq.size()); end
      auto_busy = 1'b1;
      #2 force_busy = 1'b0;
      wait_tx(4);
      auto_busy = 1'b0;
      checks += 2;
      if (txq.size() !== 4) begin failures++; $display("FAIL busy_count got=%0d want=4", txq.size()); end
      if (tx_viol !== 0 || rx_viol !== 0) begin failures++; $display("FAIL pulse_rules got=tx%0d/rx%0d want=0/0", tx_viol, rx_viol); end
      for (int i = 0; i < 4 && i < txq.size(); i++) begin
         checks++;
         if (txq[i] !== exp[i]) begin failures++; $display("FAIL busy_byte%0d got=%02h want=%02h", i, txq[i], exp[i]); end
      end
   endtask

   initial begin
      $display("[TB] uart_wb_bridge bench start");
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_discard();
      test_reset_mid_wb();
      test_back_to_back_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
